loader_write_queue: RTL

LOADER_WRITE_QUEUE -- requirements
Module: loader_write_queue

---
 rtl/loader_write_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/loader_write_queue.sv
// rtl/loader_write_queue.sv - loader byte-write queue draining into SDRAM access slots
//
// Buffers {addr, data} byte writes from the ROM loader and issues at most one
// SDRAM write per access slot. Each write is held stable for a full slot period.
//
// Ports:
//   clk       - single clock, all state changes on rising edge
//   nreset    - synchronous active-low reset, highest priority
//   wr_req    - loader write strobe, one push per high cycle
//   wr_addr   - byte address qualified by wr_req
//   wr_data   - byte qualified by wr_req
//   slot      - SDRAM access-slot strobe (one cycle in four)
//   flush     - synchronous queue clear
//   mem_we    - write enable to the SDRAM controller
//   mem_addr  - address presented with mem_we
//   mem_data  - data presented with mem_we
//   full      - queue holds DEPTH entries
//   empty     - queue holds zero entries
//   overflow  - sticky, a push was dropped
//   count     - current occupancy
//   wr_count  - completed writes since last flush/reset
module loader_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 22
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic                       wr_req,
   input  logic [AW-1:0]              wr_addr,
   input  logic [7:0]                 wr_data,
   input  logic                       slot,
   input  logic                       flush,
   output logic                       mem_we,
   output logic [AW-1:0]              mem_addr,
   output logic [7:0]                 mem_data,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     count,
   output logic [AW-1:0]              wr_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW+7:0] entries [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          pop;
   logic          push;
   logic          drop;

   always_comb begin
      full  = (count == DEPTH_C);
      empty = (count == '0);
      // Flush wins over both ends of the queue for that cycle.
      pop   = slot & ~flush & ~empty;
      // A pop in the same cycle frees the head, so a full queue can still accept.
      push  = wr_req & ~flush & (~full | pop);
      drop  = wr_req & ~flush & full & ~pop;
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (nreset && push) begin
         entries[wr_ptr] <= {wr_addr, wr_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         wr_count <= '0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else begin
         if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            wr_count <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr   <= rd_ptr + PW'(1);
               wr_count <= wr_count + AW'(1);
            end
            if (push && !pop) begin
               count <= count + CW'(1);
            end else if (pop && !push) begin
               count <= count - CW'(1);
            end
            if (drop) begin
               overflow <= 1'b1;
            end
         end

         // Outputs move only on slot edges so a write spans a whole slot period.
         // A slot coinciding with flush has pop=0 and so ends the current write.
         if (slot) begin
            mem_we <= pop;
            if (pop) begin
               {mem_addr, mem_data} <= entries[rd_ptr];
            end
         end
      end
   end

endmodule
